// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-side responder for the pipeline's load stall. It takes one load or
// store from EX, runs it on the data-memory req/gnt/rvalid bus, and then
// pulses a completion strobe. Load data is aligned and sign- or zero-extended
// before it is handed back.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ex_*_i             request from EX: load/store, size, unsigned, addr, wdata
//   flush_i            aborts a transaction that has not been granted yet
//   data_*             data-memory bus (word-aligned address, byte enables,
//                      lane-replicated write data)
//   load_data_o        formatted load result, held until the next load completes
//   valid_lsu_load_o   one-cycle pulse: load data is valid
//   store_done_o       one-cycle pulse: store acknowledged
//   misaligned_o       one-cycle pulse: misaligned or illegal request rejected
//   busy_o             transaction in flight
//
// state        | meaning
// -------------+---------------------------------------------------
// IDLE         | waiting for a request from EX
// REQ          | data_req_o high, holding the bus outputs until grant
// WAIT_RVALID  | granted; waiting for the memory response

module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_load_i,
    input  logic                      ex_store_i,
    input  logic [1:0]                ex_size_i,
    input  logic                      ex_unsigned_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
    input  logic                      flush_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [MEM_ADDR_WIDTH-1:0] data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic [DATA_WIDTH-1:0]     load_data_o,
    output logic                      valid_lsu_load_o,
    output logic                      store_done_o,
    output logic                      misaligned_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        WAIT_RVALID = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_e                      state_q, state_d;
    logic [MEM_ADDR_WIDTH-3:0]   addr_q;
    logic [1:0]                  offset_q;
    logic                        we_q;
    logic [3:0]                  be_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [1:0]                  size_q;
    logic                        unsigned_q;
    logic [DATA_WIDTH-1:0]       load_data_q;
    logic                        valid_q;
    logic                        store_done_q;
    logic                        misaligned_q;

    logic                        accept;
    logic                        reject;
    logic                        load_done;
    logic                        store_done;
    logic                        misaligned;
    logic [3:0]                  be_d;
    logic [DATA_WIDTH-1:0]       wdata_d;
    logic [DATA_WIDTH-1:0]       rdata_shifted;
    logic [DATA_WIDTH-1:0]       load_fmt;

    // Request decode: alignment check, byte enables, lane replication
    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = ex_wdata_i;
        case (ex_size_i)
            SIZE_BYTE: begin
                be_d    = 4'b0001 << ex_addr_i[1:0];
                wdata_d = {4{ex_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                misaligned = ex_addr_i[0];
                be_d       = 4'b0011 << {ex_addr_i[1], 1'b0};
                wdata_d    = {2{ex_wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                misaligned = |ex_addr_i[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        load_done  = 1'b0;
        store_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_load_i || ex_store_i) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A grant in the same cycle as a flush wins.
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    if (we_q) begin
                        store_done = 1'b1;
                    end else begin
                        load_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load alignment and extension
    always_comb begin
        rdata_shifted = data_rdata_i >> {offset_q, 3'b000};
        load_fmt      = rdata_shifted;
        case (size_q)
            SIZE_BYTE: load_fmt = {{24{~unsigned_q & rdata_shifted[7]}},  rdata_shifted[7:0]};
            SIZE_HALF: load_fmt = {{16{~unsigned_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default:   load_fmt = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            offset_q     <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            load_data_q  <= '0;
            valid_q      <= 1'b0;
            store_done_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= load_done;
            store_done_q <= store_done;
            misaligned_q <= reject;
            if (accept) begin
                addr_q     <= ex_addr_i[MEM_ADDR_WIDTH-1:2];
                offset_q   <= ex_addr_i[1:0];
                // Load wins when EX raises both strobes.
                we_q       <= ~ex_load_i;
                be_q       <= be_d;
                wdata_q    <= wdata_d;
                size_q     <= ex_size_i;
                unsigned_q <= ex_unsigned_i;
            end
            if (load_done) begin
                load_data_q <= load_fmt;
            end
        end
    end

    assign data_req_o       = (state_q == REQ);
    assign data_addr_o      = {addr_q, 2'b00};
    assign data_we_o        = we_q;
    assign data_be_o        = be_q;
    assign data_wdata_o     = wdata_q;
    assign load_data_o      = load_data_q;
    assign valid_lsu_load_o = valid_q;
    assign store_done_o     = store_done_q;
    assign misaligned_o     = misaligned_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_load_i;
    logic        ex_store_i;
    logic [1:0]  ex_size_i;
    logic        ex_unsigned_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        flush_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic [31:0] load_data_o;
    logic        valid_lsu_load_o;
    logic        store_done_o;
    logic        misaligned_o;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    load_store_unit #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_load_i        (ex_load_i),
        .ex_store_i       (ex_store_i),
        .ex_size_i        (ex_size_i),
        .ex_unsigned_i    (ex_unsigned_i),
        .ex_addr_i        (ex_addr_i),
        .ex_wdata_i       (ex_wdata_i),
        .flush_i          (flush_i),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .load_data_o      (load_data_o),
        .valid_lsu_load_o (valid_lsu_load_o),
        .store_done_o     (store_done_o),
        .misaligned_o     (misaligned_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after it was sampled.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        ex_load_i     = ld;
        ex_store_i    = st;
        ex_size_i     = sz;
        ex_unsigned_i = uns;
        ex_addr_i     = addr;
        ex_wdata_i    = wd;
        @(negedge clk);
        ex_load_i  = 1'b0;
        ex_store_i = 1'b0;
    endtask

    // Called in the REQ cycle; returns at the pulse cycle.
    task automatic bus(input int gd, input int rd, input logic [31:0] rdata);
        repeat (gd) begin
            chk("req_held", {31'd0, data_req_o}, 32'd1);
            @(negedge clk);
        end
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("req_drop", {31'd0, data_req_o}, 32'd0);
        repeat (rd - 1) @(negedge clk);
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        @(negedge clk);
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_load_i = 0; ex_store_i = 0; ex_size_i = 0; ex_unsigned_i = 0;
        ex_addr_i = 0; ex_wdata_i = 0; flush_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_req", {31'd0, data_req_o}, 32'd0);
        chk("rst_ldata", load_data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load, grant delayed two cycles
        issue(1, 0, 2'b10, 0, 32'h0000_1004, 32'd0);
        chk("w_req", {31'd0, data_req_o}, 32'd1);
        chk("w_addr", data_addr_o, 32'h0000_1004);
        chk("w_be", {28'd0, data_be_o}, 32'hF);
        chk("w_we", {31'd0, data_we_o}, 32'd0);
        chk("w_busy", {31'd0, busy_o}, 32'd1);
        bus(2, 1, 32'hDEAD_BEEF);
        chk("w_valid", {31'd0, valid_lsu_load_o}, 32'd1);
        chk("w_data", load_data_o, 32'hDEAD_BEEF);
        chk("w_busy_after", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("w_valid_once", {31'd0, valid_lsu_load_o}, 32'd0);
        chk("w_data_held", load_data_o, 32'hDEAD_BEEF);

        // Signed byte load at offset 3
        issue(1, 0, 2'b00, 0, 32'h0000_0103, 32'd0);
        chk("sb_addr", data_addr_o, 32'h0000_0100);
        chk("sb_be", {28'd0, data_be_o}, 32'h8);
        bus(0, 1, 32'h80FF_FFFF);
        chk("sb_valid", {31'd0, valid_lsu_load_o}, 32'd1);
        chk("sb_data", load_data_o, 32'hFFFF_FF80);

        // Back-to-back from the pulse cycle: unsigned byte at offset 3
        issue(1, 0, 2'b00, 1, 32'h0000_0103, 32'd0);
        bus(0, 1, 32'h80FF_FFFF);
        chk("ub_data", load_data_o, 32'h0000_0080);

        // Unsigned half at offset 2
        issue(1, 0, 2'b01, 1, 32'h0000_0102, 32'd0);
        chk("uh_be", {28'd0, data_be_o}, 32'hC);
        bus(1, 2, 32'hBEEF_1234);
        chk("uh_data", load_data_o, 32'h0000_BEEF);

        // Byte store at offset 1
        issue(0, 1, 2'b00, 0, 32'h0000_0101, 32'h1234_56AB);
        chk("bs_be", {28'd0, data_be_o}, 32'h2);
        chk("bs_wdata", data_wdata_o, 32'hABAB_ABAB);
        chk("bs_we", {31'd0, data_we_o}, 32'd1);
        chk("bs_addr", data_addr_o, 32'h0000_0100);
        bus(1, 2, 32'h0);
        chk("bs_done", {31'd0, store_done_o}, 32'd1);
        chk("bs_novalid", {31'd0, valid_lsu_load_o}, 32'd0);
        chk("bs_ldata_held", load_data_o, 32'h0000_BEEF);
        @(negedge clk);
        chk("bs_done_once", {31'd0, store_done_o}, 32'd0);

        // Load and store together act as a load
        issue(1, 1, 2'b10, 0, 32'h0000_0500, 32'h5555_5555);
        chk("ls_we", {31'd0, data_we_o}, 32'd0);
        bus(0, 1, 32'h0102_0304);
        chk("ls_valid", {31'd0, valid_lsu_load_o}, 32'd1);
        chk("ls_nostore", {31'd0, store_done_o}, 32'd0);
        chk("ls_data", load_data_o, 32'h0102_0304);

        // Misaligned word, misaligned half, illegal size
        issue(1, 0, 2'b10, 0, 32'h0000_0102, 32'd0);
        chk("mw_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("mw_req", {31'd0, data_req_o}, 32'd0);
        chk("mw_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("mw_once", {31'd0, misaligned_o}, 32'd0);
        issue(1, 0, 2'b01, 0, 32'h0000_0101, 32'd0);
        chk("mh_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("mh_req", {31'd0, data_req_o}, 32'd0);
        chk("mh_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("mh_once", {31'd0, misaligned_o}, 32'd0);
        issue(0, 1, 2'b11, 0, 32'h0000_0100, 32'd0);
        chk("mi_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("mi_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);

        // Flush in REQ without grant
        issue(1, 0, 2'b10, 0, 32'h0000_0200, 32'd0);
        chk("fl_req", {31'd0, data_req_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl_busy", {31'd0, busy_o}, 32'd0);
        chk("fl_req_off", {31'd0, data_req_o}, 32'd0);
        @(negedge clk);
        chk("fl_novalid", {31'd0, valid_lsu_load_o}, 32'd0);
        chk("fl_nostore", {31'd0, store_done_o}, 32'd0);
        chk("fl_ldata", load_data_o, 32'h0102_0304);

        // Flush together with grant: grant wins
        issue(0, 1, 2'b10, 0, 32'h0000_0204, 32'h1122_3344);
        chk("fg_wdata", data_wdata_o, 32'h1122_3344);
        flush_i    = 1'b1;
        data_gnt_i = 1'b1;
        @(negedge clk);
        flush_i    = 1'b0;
        data_gnt_i = 1'b0;
        chk("fg_busy", {31'd0, busy_o}, 32'd1);
        flush_i       = 1'b1;
        data_rvalid_i = 1'b1;
        @(negedge clk);
        flush_i       = 1'b0;
        data_rvalid_i = 1'b0;
        chk("fg_done", {31'd0, store_done_o}, 32'd1);

        // Reset while waiting for rvalid
        issue(1, 0, 2'b10, 0, 32'h0000_0300, 32'd0);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("rw_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy0", {31'd0, busy_o}, 32'd0);
        chk("rw_addr0", data_addr_o, 32'd0);
        chk("rw_be0", {28'd0, data_be_o}, 32'd0);
        chk("rw_wdata0", data_wdata_o, 32'd0);
        chk("rw_ldata0", load_data_o, 32'd0);
        chk("rw_flags0", {28'd0, valid_lsu_load_o, store_done_o, misaligned_o, data_req_o}, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h7777_7777;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        chk("rw_stray_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("rw_stray_valid", {31'd0, valid_lsu_load_o}, 32'd0);
        chk("rw_stray_ldata", load_data_o, 32'd0);
        issue(1, 0, 2'b10, 0, 32'h0000_0400, 32'd0);
        chk("rw_fresh_addr", data_addr_o, 32'h0000_0400);
        bus(0, 1, 32'hCAFE_F00D);
        chk("rw_fresh_valid", {31'd0, valid_lsu_load_o}, 32'd1);
        chk("rw_fresh_data", load_data_o, 32'hCAFE_F00D);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the pipeline control unit's load stall.
- Accepts one load or store per transaction from the EX stage and runs it on the data-memory request/grant/rvalid bus.
- For loads, aligns and sign/zero-extends the returned word, then pulses valid_lsu_load_o so the control unit can release LOAD_STALL.
- Sits between EX/WB and data memory.

Parameters:
- DATA_WIDTH, 32, data bus and register width; only 32 is supported.
- MEM_ADDR_WIDTH, 32, byte address width of the data bus.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_load_i  in  1  load request from EX, sampled in IDLE
- ex_store_i  in  1  store request from EX, sampled in IDLE
- ex_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- ex_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- ex_addr_i  in  MEM_ADDR_WIDTH  byte address
- ex_wdata_i  in  DATA_WIDTH  store data, right-aligned
- flush_i  in  1  abort a not-yet-granted transaction
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  MEM_ADDR_WIDTH  word-aligned address, bits [1:0] = 00
- data_we_o  out  1  1 = write
- data_be_o  out  4  byte enables
- data_wdata_o  out  DATA_WIDTH  lane-replicated store data
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  DATA_WIDTH  read data
- load_data_o  out  DATA_WIDTH  formatted load result, held until next load completes
- valid_lsu_load_o  out  1  one-cycle pulse: load data valid
- store_done_o  out  1  one-cycle pulse: store acknowledged
- misaligned_o  out  1  one-cycle pulse: misaligned or illegal access rejected
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0 (including load_data_o and latched addr/be/wdata). Takes effect immediately, mid-transaction included; any outstanding bus response after reset is ignored.
- States and transitions:
  - IDLE: if ex_load_i or ex_store_i, check alignment.
    - Misaligned: half with addr[0]=1; word with addr[1:0]!=00; size 11 always.
    - If misaligned: pulse misaligned_o next cycle, stay IDLE, no bus activity.
    - Otherwise: latch addr, we, be, wdata, size, unsigned, offset=addr[1:0]; go to REQ.
    - If ex_load_i and ex_store_i are both high, treat as a load.
  - REQ: data_req_o=1 and all data_* outputs stable until data_gnt_i.
    - On gnt: go to WAIT_RVALID.
    - flush_i=1 without gnt in the same cycle: back to IDLE, no pulse.
    - flush_i and gnt in the same cycle: the grant wins and the transaction completes.
  - WAIT_RVALID: data_req_o=0. On data_rvalid_i, go to IDLE and next cycle:
    - load: load_data_o updated and valid_lsu_load_o=1;
    - store: store_done_o=1.
    - flush_i in this state is ignored.
- Requests arriving while busy_o=1 are ignored; the control unit guarantees stall.
- Bus rules: rvalid never arrives in the gnt cycle or earlier. An unsolicited rvalid in IDLE/REQ is ignored.
- Minimum latency, request sampled at cycle 0:
  - cycle 1: req=1 (gnt at cycle 1)
  - cycle 2: rvalid
  - cycle 3: valid_lsu_load_o=1
- Byte enables:
  - byte: 4'b0001 << offset
  - half: 4'b0011 << (2*offset[1])
  - word: 4'b1111
- Store data:
  - byte: wdata[7:0] replicated x4
  - half: wdata[15:0] replicated x2
  - word: as is
- Load format: shift rdata right by 8*offset; keep 8/16/32 bits; extend per unsigned flag.
- Back-to-back: the cycle after returning to IDLE may accept a new request (the pulse cycle).

Test Plan:
- Word load addr 0x0000_1004, gnt delayed 2 cycles, rvalid 1 cycle after gnt, rdata 0xDEAD_BEEF -> data_addr_o=0x0000_1004, be=1111, we=0; load_data_o=0xDEAD_BEEF; valid_lsu_load_o high exactly 1 cycle; busy_o low after.
- Signed byte load addr 0x...03, rdata 0x80FF_FFFF -> load_data_o=0xFFFF_FF80. Same with ex_unsigned_i=1 -> 0x0000_0080. Unsigned half at offset 2, rdata 0xBEEF_1234 -> 0x0000_BEEF.
- Byte store addr 0x...01, wdata 0x1234_56AB -> be=0010, data_wdata_o=0xABAB_ABAB, we=1; store_done_o pulses once after rvalid; valid_lsu_load_o stays 0.
- Word load addr 0x...02, and half load addr 0x...01 -> misaligned_o one-cycle pulse each; data_req_o never asserted; busy_o stays 0.
- flush_i during REQ with gnt low -> back to IDLE next cycle, no pulses. flush_i in the same cycle as gnt -> transaction completes normally.
- rst_n low during WAIT_RVALID -> all outputs 0 immediately. Subsequent stray rvalid produces no valid_lsu_load_o; a fresh load then completes correctly.
